prog_tick_divider: RTL

- Parametrised successor to the fixed-table select rate divider.
- Generates a one-cycle tick, a 50% square wave, or a one-shot delay pulse from clk.
- Divisor is runtime-programmable through a shadow register; changes apply glitch-free at period boundaries.
- Feeds the state-automata step clock and any block needing a programmable slow strobe.

---
 rtl/prog_tick_divider.sv | 137 +++++++++++++
 1 files changed

// File: rtl/prog_tick_divider.sv
// Programmable rate divider: one-cycle tick, 50% square wave or one-shot delay pulse.
// The divisor is staged in a shadow register and taken over only at period boundaries.
module prog_tick_divider #(
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 25000000,
    parameter int TCNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              div_wr,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              start,
    output logic              tick,
    output logic              sq_out,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {IDLE, RUN, SHOT} state_t;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_PULSE   = 2'b01;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CNT_W-1:0]   div_act, div_act_next;
    logic [CNT_W-1:0]   div_shadow, div_shadow_next;
    logic               pending, pending_next;
    logic [1:0]         mode_q, mode_q_next;
    logic               tick_next, sq_next, busy_next;
    logic [TCNT_W-1:0]  tick_count_next;

    logic               tc, mode_chg, run_mode;
    logic [CNT_W-1:0]   div_upd, div_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            div_act    <= DEF_DIV;
            div_shadow <= DEF_DIV;
            pending    <= 1'b0;
            mode_q     <= MODE_OFF;
            tick       <= 1'b0;
            sq_out     <= 1'b0;
            busy       <= 1'b0;
            tick_count <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            div_act    <= div_act_next;
            div_shadow <= div_shadow_next;
            pending    <= pending_next;
            mode_q     <= mode_q_next;
            tick       <= tick_next;
            sq_out     <= sq_next;
            busy       <= busy_next;
            tick_count <= tick_count_next;
        end
    end

    // A divisor written on the boundary edge itself wins over the staged one
    always_comb begin
        tc       = (div_act != '0) && (cnt == div_act - 1'b1);
        mode_chg = (mode != mode_q);
        run_mode = (mode == MODE_PULSE) || (mode == MODE_SQUARE);
        div_upd  = div_wr ? div_val : (pending ? div_shadow : div_act);
        div_eff  = pending ? div_shadow : div_act;

        state_next      = state;
        cnt_next        = cnt;
        div_act_next    = div_act;
        div_shadow_next = div_wr ? div_val : div_shadow;
        pending_next    = pending | div_wr;
        mode_q_next     = mode_q;
        tick_next       = 1'b0;
        sq_next         = sq_out;
        busy_next       = busy;
        tick_count_next = tick_count + TCNT_W'(tick);

        if (en) begin
            mode_q_next = mode;
            if (mode_chg) begin
                cnt_next     = '0;
                sq_next      = 1'b0;
                busy_next    = 1'b0;
                div_act_next = div_upd;
                pending_next = 1'b0;
                state_next   = (run_mode && div_upd != '0) ? RUN : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_next = '0;
                        sq_next  = 1'b0;
                        if (pending) begin
                            div_act_next = div_shadow;
                            pending_next = div_wr;
                        end
                        if (run_mode && div_eff != '0) begin
                            state_next = RUN;
                        end else if (mode == MODE_ONESHOT && start &&
                                     div_act != '0 && div_eff != '0) begin
                            state_next = SHOT;
                            busy_next  = 1'b1;
                        end
                    end
                    RUN, SHOT: begin
                        if (tc) begin
                            cnt_next     = '0;
                            tick_next    = 1'b1;
                            div_act_next = div_upd;
                            pending_next = 1'b0;
                            if (state == SHOT) begin
                                busy_next  = 1'b0;
                                state_next = IDLE;
                            end else if (div_upd == '0) begin
                                sq_next    = 1'b0;
                                state_next = IDLE;
                            end else if (mode == MODE_SQUARE) begin
                                sq_next = ~sq_out;
                            end
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

endmodule
